slot_timer_gen: RTL and testbench

SLOT_TIMER_GEN -- requirements
Module: slot_timer_gen

---
 rtl/slot_timer_gen.sv | 157 +++++++++++++++
 tb/tb_slot_timer_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_timer_gen.sv
// slot_timer_gen
//   Generates slot boundaries for a gate-control-list schedule. A slot lasts
//   cyc_act clock cycles. Slots are numbered within a group (slot_shift_cnt)
//   and within a period (slot_ID). The GCL RAM is asked for the next group
//   PREFETCH cycles before the current group ends. A small control FSM
//   produces the test timestamp and the statistics counter-clear.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_test_start     : level, schedule running while high
//   in_test_stop      : level, test stopped by configuration
//   in_slot_cycle     : slot length in clk cycles
//   in_slot_cycle_wr  : one-cycle strobe qualifying in_slot_cycle
//   cnt_rst           : counter-clear to downstream statistics blocks
//   timestamp         : free-running test time (wraps silently)
//   slot_shift        : toggles at each slot boundary
//   slot_pulse        : one-cycle pulse at each slot boundary
//   slot_shift_cnt    : slot index within the GCL group
//   slot_ID           : slot index within the period
//   period_wrap       : one-cycle pulse when slot_ID wraps to 0
//   gcl_ram_rd        : one-cycle GCL group prefetch strobe
//   cfg_err           : active slot length too short to be usable
module slot_timer_gen #(
  parameter int          SLOT_W   = 9,
  parameter int          GRP_W    = 4,
  parameter int          CYC_W    = 20,
  parameter int          TS_W     = 48,
  parameter int          PREFETCH = 3,
  parameter int unsigned HOLD_CYC = 750_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_test_start,
  input  logic              in_test_stop,
  input  logic [CYC_W-1:0]  in_slot_cycle,
  input  logic              in_slot_cycle_wr,
  output logic              cnt_rst,
  output logic [TS_W-1:0]   timestamp,
  output logic              slot_shift,
  output logic              slot_pulse,
  output logic [GRP_W-1:0]  slot_shift_cnt,
  output logic [SLOT_W-1:0] slot_ID,
  output logic              period_wrap,
  output logic              gcl_ram_rd,
  output logic              cfg_err
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       hold;
  logic [31:0]       hold_nxt;

  logic [CYC_W-1:0]  cyc_act;
  logic [CYC_W-1:0]  cyc_shd;
  logic [CYC_W-1:0]  slot_cnt;
  logic              slot_end;
  logic              wrap_now;
  logic              grp_pref;

  // A slot shorter than PREFETCH+1 cycles cannot host the prefetch point.
  assign cfg_err  = (cyc_act <= CYC_W'(PREFETCH));
  assign slot_end = (slot_cnt == cyc_act - CYC_W'(1));
  assign wrap_now = in_test_start && !cfg_err && slot_end && (slot_ID == '1);
  assign grp_pref = in_test_start && !cfg_err && (slot_shift_cnt == '1) &&
                    (slot_cnt == cyc_act - CYC_W'(PREFETCH + 1));

  // Slot length registers. While running, a write only reaches the shadow;
  // the shadow is promoted on the period wrap so the new length starts
  // cleanly at slot 0. The two branches never coincide (wrap needs start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_act <= '0;
      cyc_shd <= '0;
    end else begin
      if (in_slot_cycle_wr) cyc_shd <= in_slot_cycle;
      if (in_slot_cycle_wr && !in_test_start) cyc_act <= in_slot_cycle;
      else if (wrap_now)                      cyc_act <= cyc_shd;
    end
  end

  // Slot counter and slot/group/period indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt       <= '0;
      slot_shift     <= 1'b0;
      slot_shift_cnt <= '0;
      slot_ID        <= '0;
      slot_pulse     <= 1'b0;
      period_wrap    <= 1'b0;
      gcl_ram_rd     <= 1'b0;
    end else begin
      slot_pulse  <= 1'b0;
      period_wrap <= 1'b0;
      gcl_ram_rd  <= grp_pref;
      if (!in_test_start) begin
        slot_cnt       <= '0;
        slot_shift     <= 1'b0;
        slot_shift_cnt <= '0;
        slot_ID        <= '0;
      end else if (cfg_err) begin
        // slot_shift keeps its level; only the counters are parked.
        slot_cnt       <= '0;
        slot_shift_cnt <= '0;
        slot_ID        <= '0;
      end else if (slot_end) begin
        slot_cnt       <= '0;
        slot_shift     <= ~slot_shift;
        slot_pulse     <= 1'b1;
        slot_shift_cnt <= slot_shift_cnt + GRP_W'(1);
        slot_ID        <= slot_ID + SLOT_W'(1);
        period_wrap    <= wrap_now;
      end else begin
        slot_cnt <= slot_cnt + CYC_W'(1);
      end
    end
  end

  // Control FSM next state. The hold counter runs while stopped and
  // saturates at HOLD_CYC-1, which marks the end of the drain window.
  always_comb begin
    state_nxt = IDLE;
    hold_nxt  = '0;
    if (in_test_start) begin
      state_nxt = RUN;
    end else if (in_test_stop) begin
      if (hold == HOLD_LAST) begin
        state_nxt = DONE;
        hold_nxt  = hold;
      end else begin
        state_nxt = DRAIN;
        hold_nxt  = hold + 32'd1;
      end
    end
  end

  always_comb begin
    cnt_rst = 1'b0;
    if (state == IDLE || state == DONE) cnt_rst = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      timestamp <= '0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      timestamp <= (state_nxt == IDLE) ? '0 : timestamp + TS_W'(1);
    end
  end

endmodule

// File: tb/tb_slot_timer_gen.sv
// Testbench for slot_timer_gen: directed phases followed by a random phase,
// every cycle compared against a slot-count based reference model.
module tb_slot_timer_gen;

  localparam int SLOT_W = 3;
  localparam int GRP_W  = 2;
  localparam int CYC_W  = 20;
  localparam int TS_W   = 48;
  localparam int PREF   = 3;
  localparam int HOLD   = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [CYC_W-1:0]  cyc;
  logic              wr;
  logic              cnt_rst;
  logic [TS_W-1:0]   timestamp;
  logic              slot_shift;
  logic              slot_pulse;
  logic [GRP_W-1:0]  slot_shift_cnt;
  logic [SLOT_W-1:0] slot_ID;
  logic              period_wrap;
  logic              gcl_ram_rd;
  logic              cfg_err;

  slot_timer_gen #(
    .SLOT_W(SLOT_W), .GRP_W(GRP_W), .CYC_W(CYC_W), .TS_W(TS_W),
    .PREFETCH(PREF), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_test_start(start), .in_test_stop(stop),
    .in_slot_cycle(cyc), .in_slot_cycle_wr(wr),
    .cnt_rst(cnt_rst), .timestamp(timestamp),
    .slot_shift(slot_shift), .slot_pulse(slot_pulse),
    .slot_shift_cnt(slot_shift_cnt), .slot_ID(slot_ID),
    .period_wrap(period_wrap), .gcl_ram_rd(gcl_ram_rd), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: total slots since the counters were last cleared,
  // cycles elapsed in the current slot, and consecutive stopped edges.
  int          m_act, m_shd, m_cnt, m_slot, m_stopcnt;
  bit          m_shift, m_pulse, m_wrap, m_rd, m_cntrst;
  logic [47:0] m_ts;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_shd = 0; m_cnt = 0; m_slot = 0; m_stopcnt = 0;
    m_shift = 0; m_pulse = 0; m_wrap = 0; m_rd = 0; m_cntrst = 1; m_ts = '0;
  endtask

  task automatic model_edge();
    bit err;
    int n_act, n_shd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    err   = (m_act <= PREF);
    m_rd  = start && !err && (m_slot % 4 == 3) && (m_cnt == m_act - 1 - PREF);
    n_act = m_act;
    n_shd = m_shd;
    m_pulse = 0;
    m_wrap  = 0;
    if (!start) begin
      m_cnt = 0; m_slot = 0; m_shift = 0;
    end else if (err) begin
      m_cnt = 0; m_slot = 0;
    end else if (m_cnt == m_act - 1) begin
      m_cnt   = 0;
      m_slot  = m_slot + 1;
      m_shift = !m_shift;
      m_pulse = 1;
      m_wrap  = (m_slot % 8 == 0);
      if (m_wrap) n_act = m_shd;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (wr) begin
      n_shd = int'(cyc);
      if (!start) n_act = int'(cyc);
    end
    m_act = n_act;
    m_shd = n_shd;
    if (start) begin
      m_stopcnt = 0; m_ts = m_ts + 1; m_cntrst = 0;
    end else if (stop) begin
      m_stopcnt = m_stopcnt + 1; m_ts = m_ts + 1; m_cntrst = (m_stopcnt >= HOLD);
    end else begin
      m_stopcnt = 0; m_ts = '0; m_cntrst = 1;
    end
  endtask

  task automatic check_all();
    chk("cnt_rst",        cnt_rst,        m_cntrst);
    chk("timestamp",      timestamp,      m_ts);
    chk("slot_shift",     slot_shift,     m_shift);
    chk("slot_pulse",     slot_pulse,     m_pulse);
    chk("slot_shift_cnt", slot_shift_cnt, m_slot % 4);
    chk("slot_ID",        slot_ID,        m_slot % 8);
    chk("period_wrap",    period_wrap,    m_wrap);
    chk("gcl_ram_rd",     gcl_ram_rd,     m_rd);
    chk("cfg_err",        cfg_err,        (m_act <= PREF));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive_wr(input int val);
    cyc = CYC_W'(val);
    wr  = 1'b1;
    step();
    wr  = 1'b0;
  endtask

  int npulse, nrd, nwrap, nlow, t_wrap, t_next, idx;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cyc = '0; wr = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // Slot length 10 written idle, then run two full groups and a period.
    drive_wr(10);
    start = 1'b1;
    npulse = 0; nrd = 0; nwrap = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      npulse += int'(slot_pulse);
      nrd    += int'(gcl_ram_rd);
      nwrap  += int'(period_wrap);
    end
    chk("pulse_count_80", npulse, 8);
    chk("gcl_rd_count_80", nrd, 2);
    chk("wrap_count_80", nwrap, 1);

    // Change slot length to 16 during slot 2; takes effect after the wrap.
    for (int i = 0; i < 100 && (m_slot % 8 != 2); i++) step();
    drive_wr(16);
    t_wrap = -1; t_next = -1; idx = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      idx++;
      if (period_wrap && t_wrap < 0) t_wrap = idx;
      else if (slot_pulse && t_wrap >= 0 && t_next < 0) t_next = idx;
    end
    chk("new_len_seen", (t_wrap >= 0 && t_next >= 0), 1);
    chk("new_len_interval", t_next - t_wrap, 16);

    // Stop with drain window, then back to idle.
    start = 1'b0; stop = 1'b1;
    nlow = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nlow += int'(!cnt_rst);
    end
    chk("drain_low_cycles", nlow, HOLD - 1);
    stop = 1'b0;
    step();
    chk("idle_timestamp", timestamp, 0);
    chk("idle_cnt_rst", cnt_rst, 1);

    // Too-short slot length blocks the schedule; 4 is the first usable one.
    drive_wr(3);
    chk("cfg_err_len3", cfg_err, 1);
    start = 1'b1;
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      npulse += int'(slot_pulse);
    end
    chk("pulse_count_len3", npulse, 0);
    start = 1'b0;
    step();
    drive_wr(4);
    chk("cfg_err_len4", cfg_err, 0);
    start = 1'b1;
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      npulse += int'(slot_pulse);
    end
    chk("pulse_count_len4", npulse, 7);

    // Asynchronous reset in the middle of a slot.
    drive_wr(9);
    start = 1'b0;
    step();
    drive_wr(9);
    start = 1'b1;
    for (int i = 0; i < 14; i++) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    #2 rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      npulse += int'(slot_pulse);
    end
    chk("pulse_after_reset", npulse, 0);

    // Random phase.
    start = 1'b0;
    step();
    drive_wr(6);
    start = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) start = !start;
      if ($urandom_range(0, 29) == 0) stop = !stop;
      wr = ($urandom_range(0, 15) == 0);
      if (wr) cyc = CYC_W'($urandom_range(2, 12));
      step();
      wr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
